// File: rtl/spi_burst_ctrl_pkg.sv
// Shared types and constants for the SPI burst sequencer and its byte FIFOs.
package spi_burst_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_CAPTURE = 3'd5
  } burst_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// First-word-fall-through byte FIFO; pointers carry one extra wrap bit so
// occupancy is their plain difference and full/empty need no extra flag.
module spi_byte_fifo
  import spi_burst_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_wr;
  logic              w_rd;

  assign w_wr = wr_en & ~full;
  assign w_rd = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; contents are only visible once a pointer covers them.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  assign count   = r_wr_ptr - r_rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of a single-byte SPI master: queues TX bytes, issues
// one start per byte on go, and collects each received byte into an RX FIFO.
module spi_burst_ctrl
  import spi_burst_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              go,
  output logic              busy,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [AW:0]       rx_count,
  output logic              spi_start,
  output logic [BYTE_W-1:0] spi_data_in,
  input  logic              spi_cs,
  input  logic [BYTE_W-1:0] spi_data_out
);

  burst_state_e      r_state;
  burst_state_e      w_state_nxt;
  logic [AW:0]       r_burst_cnt;
  logic [BYTE_W-1:0] r_spi_data;

  logic              w_tx_full;
  logic              w_tx_empty;
  logic [AW:0]       w_tx_count;
  logic [BYTE_W-1:0] w_tx_head;
  logic              w_tx_pop;

  logic              w_rx_full;
  logic              w_rx_empty;
  logic [AW:0]       w_rx_count;
  logic [BYTE_W-1:0] w_rx_head;
  logic              w_rx_push;

  logic              w_go_accept;

  // Burst length is a snapshot of the TX queue; later writes wait for the next go.
  assign w_go_accept = go & (r_state == ST_IDLE) & (w_tx_count != '0);

  spi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (w_tx_pop),
    .rd_data (w_tx_head),
    .full    (w_tx_full),
    .empty   (w_tx_empty),
    .count   (w_tx_count)
  );

  spi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_rx_push),
    .wr_data (spi_data_out),
    .rd_en   (rx_ready),
    .rd_data (w_rx_head),
    .full    (w_rx_full),
    .empty   (w_rx_empty),
    .count   (w_rx_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_accept) w_state_nxt = ST_LOAD;
      end
      // Holding here while RX is full guarantees the capture slot exists.
      ST_LOAD: begin
        if (!w_rx_full && !w_tx_empty) begin
          w_tx_pop    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START:   w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (!spi_cs) w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (spi_cs)  w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        w_rx_push   = 1'b1;
        w_state_nxt = (r_burst_cnt == (AW+1)'(1)) ? ST_IDLE : ST_LOAD;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_spi_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go_accept)
        r_burst_cnt <= w_tx_count;
      else if (r_state == ST_CAPTURE)
        r_burst_cnt <= r_burst_cnt - 1'b1;
      if (w_tx_pop) r_spi_data <= w_tx_head;
    end
  end

  assign tx_ready    = ~w_tx_full;
  assign busy        = (r_state != ST_IDLE);
  assign rx_data     = w_rx_head;
  assign rx_valid    = ~w_rx_empty;
  assign rx_count    = w_rx_count;
  assign spi_start   = (r_state == ST_START);
  assign spi_data_in = r_spi_data;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl: loopback SPI master model plus
// queue-based scoreboard of TX contents and expected RX bytes.
module tb_spi_burst_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        go;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [AW:0] rx_count;
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic        spi_cs;
  logic [7:0]  spi_data_out;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .go           (go),
    .busy         (busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_count     (rx_count),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_cs       (spi_cs),
    .spi_data_out (spi_data_out)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];
  int         starts = 0;
  int         exp_starts = 0;
  logic [7:0] m_mask = 8'h00;
  int         m_lat = 2;

  typedef struct {
    logic [7:0] data;
    logic [7:0] mask;
    int         lat;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master model: one byte per start, cs low for a few cycles, returns MOSI^mask.
  initial begin
    logic [7:0] m_byte;
    spi_cs       = 1'b1;
    spi_data_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (spi_start && !rst) begin
        m_byte = spi_data_in;
        starts++;
        @(posedge clk);
        #1;
        spi_cs = 1'b0;
        for (int k = 0; k < m_lat && !rst; k++) begin
          @(posedge clk);
          #1;
        end
        spi_data_out = m_byte ^ m_mask;
        spi_cs       = 1'b1;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d, input bit idle);
    if (idle) chk("tx_ready", 32'(tx_ready), 32'(tx_q.size() < DEPTH));
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
  endtask

  task automatic do_go(input bit accept);
    int n;
    n  = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    if (accept) begin
      n = tx_q.size();
      repeat (n) exp_q.push_back(tx_q.pop_front() ^ m_mask);
      exp_starts += n;
      chk("busy_after_go", 32'(busy), 32'(n > 0));
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 4000) begin
      tick();
      c++;
    end
    chk("burst_done", 32'(busy), 32'd0);
    chk("start_count", 32'(starts), 32'(exp_starts));
  endtask

  task automatic drain(input bit rand_ready);
    int c;
    c = 0;
    while ((busy || rx_valid || exp_q.size() != 0) && c < 6000) begin
      rx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
        else                   chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      tick();
      c++;
    end
    rx_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("rx_valid_end", 32'(rx_valid), 32'd0);
    chk("start_count", 32'(starts), 32'(exp_starts));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    vecs[0] = '{data: 8'hA5, mask: 8'h00, lat: 3, exp_rx: 8'hA5};
    vecs[1] = '{data: 8'h3C, mask: 8'hFF, lat: 1, exp_rx: 8'hC3};
    vecs[2] = '{data: 8'h00, mask: 8'h5A, lat: 5, exp_rx: 8'h5A};
    vecs[3] = '{data: 8'hFF, mask: 8'h0F, lat: 2, exp_rx: 8'hF0};
    vecs[4] = '{data: 8'h81, mask: 8'h81, lat: 4, exp_rx: 8'h00};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; go = 1'b0; rx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_spi_data_in", 32'(spi_data_in), 32'd0);
    rst = 1'b0;
    tick();

    // Single-byte loopback table
    for (int i = 0; i < 5; i++) begin
      m_mask = vecs[i].mask;
      m_lat  = vecs[i].lat;
      write_byte(vecs[i].data, 1'b1);
      do_go(1'b1);
      wait_idle();
      chk("vec_rx_data", 32'(rx_data), 32'(vecs[i].exp_rx));
      chk("vec_rx_count", 32'(rx_count), 32'd1);
      chk("vec_spi_start", 32'(spi_start), 32'd0);
      drain(1'b0);
    end

    // 16-byte burst fills TX, then fills RX
    m_mask = 8'h00;
    m_lat  = 2;
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
    write_byte(8'hEE, 1'b1);
    do_go(1'b1);
    wait_idle();
    chk("full_rx_count", 32'(rx_count), 32'd16);

    // RX full: the next burst must stall in LOAD without losing bytes
    for (int i = 20; i < 24; i++) write_byte(8'(i), 1'b1);
    do_go(1'b1);
    repeat (30) tick();
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_rx_count", 32'(rx_count), 32'd16);
    chk("stall_starts", 32'(starts), 32'(exp_starts - 4));
    drain(1'b0);

    // go with empty TX, then go while busy
    do_go(1'b1);
    repeat (5) tick();
    chk("empty_go_busy", 32'(busy), 32'd0);
    chk("empty_go_starts", 32'(starts), 32'(exp_starts));
    for (int i = 0; i < 3; i++) write_byte(8'h40 + 8'(i), 1'b1);
    do_go(1'b1);
    write_byte(8'h50, 1'b0);
    write_byte(8'h51, 1'b0);
    do_go(1'b0);
    wait_idle();
    drain(1'b0);
    do_go(1'b1);
    wait_idle();
    drain(1'b0);

    // Writes during a 2-byte burst stay queued for the next burst
    write_byte(8'h61, 1'b1);
    write_byte(8'h62, 1'b1);
    do_go(1'b1);
    write_byte(8'h71, 1'b0);
    write_byte(8'h72, 1'b0);
    write_byte(8'h73, 1'b0);
    wait_idle();
    do_go(1'b1);
    wait_idle();
    drain(1'b0);

    // Reset while the master holds cs low
    write_byte(8'h11, 1'b1);
    do_go(1'b1);
    wait_idle();
    m_lat = 30;
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    do_go(1'b1);
    c = 0;
    while (spi_cs && c < 100) begin
      tick();
      c++;
    end
    chk("cs_low_seen", 32'(spi_cs), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_count", 32'(rx_count), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_spi_start", 32'(spi_start), 32'd0);
    chk("mid_rst_spi_data_in", 32'(spi_data_in), 32'd0);
    tx_q.delete();
    exp_q.delete();
    exp_starts -= 1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_starts", 32'(starts), 32'(exp_starts));

    // Randomized bursts against the queue model
    for (int it = 0; it < 40; it++) begin
      m_mask = 8'($urandom);
      m_lat  = $urandom_range(1, 4);
      k      = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) write_byte(8'($urandom), 1'b1);
      do_go(1'b1);
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) write_byte(8'($urandom), 1'b0);
      drain(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
